// File: rtl/execute_stage.sv
// Execute stage, directly downstream of the ID/EX pipeline register.
//
// Computes the ALU result for the incoming instruction and registers it,
// together with the store data (DR2) and the memory-stage control bits.
// Single-cycle operations complete in one clock. MUL is an iterative
// shift-add multiply that runs for DATA_W steps. stall_out is high for the
// whole multiply, and the upstream register holds its contents while it is high.
//
// Ports:
//   clk, rst_n            clock and synchronous active-low reset
//   valid_in              DR1/DR2/alucode/control carry a real instruction
//   DR1, DR2              operands A and B (B is also the store data)
//   alucode               operation select (0..11, 12..15 reserved -> 0)
//   *_in control bits     demux_sel/WE/W/R forwarded to the memory stage
//   stall_out             multiplier busy
//   valid_out             registered outputs hold a completed instruction
//   result_out, zero_out  ALU result and its zero flag
//   store_data_out        registered DR2
//   *_out control bits    registered control bits (0 on bubbles)
module execute_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] DR1,
  input  logic [DATA_W-1:0] DR2,
  input  logic [3:0]        alucode,
  input  logic              demux_sel_in,
  input  logic              WE_in,
  input  logic              W_in,
  input  logic              R_in,
  output logic              stall_out,
  output logic              valid_out,
  output logic [DATA_W-1:0] result_out,
  output logic [DATA_W-1:0] store_data_out,
  output logic              zero_out,
  output logic              demux_sel_out,
  output logic              WE_out,
  output logic              W_out,
  output logic              R_out
);

  localparam logic [3:0]       AluMul   = 4'd10;
  localparam logic [CNT_W-1:0] LastStep = CNT_W'(DATA_W - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   store_lat_q, store_lat_d;
  logic [3:0]          ctrl_lat_q, ctrl_lat_d;

  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                zero_q, zero_d;
  logic [DATA_W-1:0]   store_q, store_d;
  logic [3:0]          ctrl_q, ctrl_d;

  logic [DATA_W-1:0]   alu_res;
  logic [DATA_W-1:0]   acc_step;
  logic [CNT_W-1:0]    shamt;

  assign shamt = DR2[CNT_W-1:0];

  always_comb begin
    alu_res = '0;
    case (alucode)
      4'd0:    alu_res = DR1 + DR2;
      4'd1:    alu_res = DR1 - DR2;
      4'd2:    alu_res = DR1 & DR2;
      4'd3:    alu_res = DR1 | DR2;
      4'd4:    alu_res = DR1 ^ DR2;
      4'd5:    alu_res = DR1 << shamt;
      4'd6:    alu_res = DR1 >> shamt;
      4'd7:    alu_res = $unsigned($signed(DR1) >>> shamt);
      4'd8:    alu_res = {{(DATA_W-1){1'b0}}, $signed(DR1) < $signed(DR2)};
      4'd9:    alu_res = {{(DATA_W-1){1'b0}}, DR1 < DR2};
      4'd11:   alu_res = DR2;
      default: alu_res = '0; // MUL handled by the iterative path; 12..15 reserved
    endcase
  end

  // One shift-add step; the completing edge uses it directly so the last
  // partial product lands in result_out on the same edge.
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    store_lat_d = store_lat_q;
    ctrl_lat_d  = ctrl_lat_q;
    valid_d     = 1'b0;
    result_d    = result_q;
    zero_d      = zero_q;
    store_d     = store_q;
    ctrl_d      = 4'b0000;
    case (state_q)
      StIdle: begin
        if (valid_in) begin
          if (alucode == AluMul) begin
            state_d     = StBusy;
            cnt_d       = '0;
            mcand_d     = DR1;
            mplier_d    = DR2;
            acc_d       = '0;
            store_lat_d = DR2;
            ctrl_lat_d  = {demux_sel_in, WE_in, W_in, R_in};
          end else begin
            valid_d  = 1'b1;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            store_d  = DR2;
            ctrl_d   = {demux_sel_in, WE_in, W_in, R_in};
          end
        end
      end
      StBusy: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LastStep) begin
          state_d  = StIdle;
          valid_d  = 1'b1;
          result_d = acc_step;
          zero_d   = (acc_step == '0);
          store_d  = store_lat_q;
          ctrl_d   = ctrl_lat_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      store_lat_q <= '0;
      ctrl_lat_q  <= '0;
      valid_q     <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      store_q     <= '0;
      ctrl_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      store_lat_q <= store_lat_d;
      ctrl_lat_q  <= ctrl_lat_d;
      valid_q     <= valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      store_q     <= store_d;
      ctrl_q      <= ctrl_d;
    end
  end

  assign stall_out      = (state_q == StBusy);
  assign valid_out      = valid_q;
  assign result_out     = result_q;
  assign zero_out       = zero_q;
  assign store_data_out = store_q;
  assign demux_sel_out  = ctrl_q[3];
  assign WE_out         = ctrl_q[2];
  assign W_out          = ctrl_q[1];
  assign R_out          = ctrl_q[0];

endmodule
